id_hazard_ctrl: RTL
===================

# id_hazard_ctrl

Pipeline sequencing controller for the ID stage of the 5-stage RV32I core. It decodes the source registers of the instruction held in IF/ID and compares them against the instruction in ID/EX. It then drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble. A small FSM stretches load-use stalls and post-redirect flushes over configurable cycle counts, and the controller freezes the whole front end while data memory is busy.

## Interface
- `LU_STALL_CYCLES`, default 1: total stall cycles per load-use hazard, counting the detection cycle; legal range 1–15.
- `FLUSH_CYCLES`, default 1: extra squash cycles after a redirect cycle, covering synchronous I-mem latency; legal range 0–15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_inst`  in  32  instruction currently in IF/ID.
- `id_valid`  in  1  IF/ID holds a real instruction.
- `ex_valid`  in  1  ID/EX holds a real instruction.
- `ex_mem_read`  in  1  the ID/EX instruction is `lw`.
- `ex_rd`  in  5  destination register of the ID/EX instruction.
- `ex_redirect`  in  1  branch taken or jump resolved in EX this cycle.
- `mem_stall`  in  1  data memory busy; freeze everything.
- `pc_we`  out  1  PC register write enable.
- `if_id_we`  out  1  IF/ID write enable.
- `if_id_flush`  out  1  clear IF/ID to invalid.
- `id_ex_bubble`  out  1  load a NOP into ID/EX, with all control fields cleared.
- `stall_cycles`  out  32  only with `HAZARD_PERF_CNT_EN`.
- `flush_cycles`  out  32  only with `HAZARD_PERF_CNT_EN`.

## Operation
- **Source decode** from `id_inst[6:0]`. `rs1=[19:15]`, `rs2=[24:20]`.
  - `rs1` is used by 0110011, 0010011, 0000011, 0100011 and 1100011.
  - `rs2` is used by 0110011, 0100011 and 1100011.
  - 1101111 and all other opcodes use neither source.
- **Load-use hit** (`lu`) when all of the following hold: `id_valid`, `ex_valid`, `ex_mem_read` and `ex_rd!=0`, and at least one of (rs1 used and `rs1==ex_rd`) or (rs2 used and `rs2==ex_rd`). x0 never hazards.
- **FSM states:** RUN, LU_STALL, FLUSH. There is a 4-bit down counter `cnt`.
- **Priority** from highest to lowest: `mem_stall` > `ex_redirect` > load-use hit > normal.
- **`mem_stall`:** `pc_we=0`, `if_id_we=0`, `if_id_flush=0`, `id_ex_bubble=0`. State, `cnt` and the counters all hold.
- **`ex_redirect`, in any state:** `pc_we=1`, `if_id_flush=1`, `id_ex_bubble=1`.
  - If `FLUSH_CYCLES>0`, go to FLUSH with `cnt=FLUSH_CYCLES`.
  - Otherwise go to RUN.
  - A redirect aborts any load-use stall in progress.
- **RUN with `lu`:** `pc_we=0`, `if_id_we=0`, `id_ex_bubble=1`.
  - If `LU_STALL_CYCLES>1`, go to LU_STALL with `cnt=LU_STALL_CYCLES-1`.
- **RUN, otherwise:** `pc_we=1`, `if_id_we=1`, flush and bubble at 0.
- **LU_STALL:** same outputs as a load-use hit, regardless of `lu`.
  - `cnt` decrements; when `cnt==1`, go to RUN on this edge.
- **FLUSH:** `pc_we=1`, `if_id_flush=1`, `id_ex_bubble=1`. Load-use detection is suppressed.
  - `cnt` decrements; when `cnt==1`, go to RUN.

## Timing
- All outputs are combinational from state, `cnt` and the inputs, so they act in the same cycle as the hazard.
- Load-use stall length is exactly `LU_STALL_CYCLES` cycles. Redirect squash length is exactly `1+FLUSH_CYCLES` cycles.
- Cycles frozen by `mem_stall` extend either window 1:1; they do not consume `cnt`.
- **While `rst_n=0`:** state RUN, `cnt=0`, `pc_we=0`, `if_id_we=0`, `if_id_flush=1`, `id_ex_bubble=1`, counters 0.
- **First edge after release:** RUN outputs.
- **Reset mid-stall or mid-flush:** the controller returns to RUN immediately and nothing is resumed.

## Configuration
- **`HAZARD_PERF_CNT_EN` defined:** the `stall_cycles` and `flush_cycles` ports exist.
  - `stall_cycles` increments on each non-`mem_stall` cycle with `pc_we=0`.
  - `flush_cycles` increments on each non-`mem_stall` cycle with `if_id_flush=1`.
  - Both counters wrap from 0xFFFFFFFF to 0. Both reset to 0.
- **Not defined:** the ports and counter logic are absent, and all other behaviour is identical.

## Test plan
- **Load-use:** `ex_mem_read=1`, `ex_rd=5`, `id_inst`=`add x6,x5,x7` (0x00728333). With `LU_STALL_CYCLES=2`, `pc_we`/`if_id_we` are 0 and `id_ex_bubble` is 1 for exactly 2 cycles, then RUN.
- **x0 / unused source:** `ex_rd=0` with rs1=0 gives no stall. `jal` with bits [19:15]=`ex_rd` gives no stall. `sw x5,0(x1)` with `ex_rd=5` stalls, because rs2 is used.
- **Redirect priority:** `ex_redirect=1` in the middle of an LU_STALL. With `FLUSH_CYCLES=1`, `if_id_flush=1` for 2 cycles and `pc_we=1`, then RUN; the stall is aborted.
- **`mem_stall` freeze:** assert `mem_stall` for 3 cycles inside FLUSH. All outputs are 0, and the FLUSH window resumes with its remaining count unchanged.
- **Reset:** drop `rst_n` mid-FLUSH. Outputs immediately show `if_id_flush=1`, `id_ex_bubble=1`, `pc_we=0`. After release the controller is in RUN and the counters read 0.
- **Perf counters (`HAZARD_PERF_CNT_EN`):** 3 load-use stalls (`LU_STALL_CYCLES=1`) and 2 redirects (`FLUSH_CYCLES=1`) give `stall_cycles=3` and `flush_cycles=4`.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl
//   ID-stage sequencing controller for the 5-stage RV32I core. It decodes the
//   source registers of the IF/ID instruction and checks them against a load
//   in ID/EX. It then drives the PC and IF/ID enables, the IF/ID flush and the
//   ID/EX bubble. A small FSM stretches load-use stalls (LU_STALL_CYCLES) and
//   post-redirect squashes (1 + FLUSH_CYCLES). mem_stall freezes everything.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   id_inst, id_valid     instruction in IF/ID
//   ex_valid, ex_mem_read, ex_rd   instruction in ID/EX (lw when ex_mem_read)
//   ex_redirect           taken branch / jump resolved in EX
//   mem_stall             data memory busy
//   pc_we, if_id_we       front-end write enables
//   if_id_flush           clear IF/ID to invalid
//   id_ex_bubble          load a NOP into ID/EX
//   stall_cycles, flush_cycles   perf counters (HAZARD_PERF_CNT_EN only)
//
// Build option
//   HAZARD_PERF_CNT_EN    adds the stall_cycles / flush_cycles counters.
module id_hazard_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1,  // 1..15
    parameter int unsigned FLUSH_CYCLES    = 1   // 0..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_stall,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_bubble
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU_STALL,
        ST_FLUSH
    } state_e;

    localparam logic [3:0] LU_CNT = 4'(LU_STALL_CYCLES - 1);
    localparam logic [3:0] FL_CNT = 4'(FLUSH_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // ---------------- source decode / load-use detect ----------------
    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used, lu;

    assign opcode = id_inst[6:0];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            7'b0010011, 7'b0000011: rs1_used = 1'b1;
            default: ;
        endcase
    end

    // x0 never hazards, so ex_rd==0 masks the hit.
    assign lu = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));

    // ---------------- outputs and next state ----------------
    // While squashing, IF/ID keeps loading; the flush clears whatever lands.
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (!rst_n) begin
            // Reset drives the outputs directly; state is held by the flops.
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES > 0) begin
                state_d = ST_FLUSH;
                cnt_d   = FL_CNT;
            end else begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lu) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            state_d = ST_LU_STALL;
                            cnt_d   = LU_CNT;
                        end
                    end
                end
                ST_LU_STALL: begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ---------------- performance counters ----------------
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (!mem_stall) begin
            if (!pc_we)      stall_cycles_d = stall_cycles_q + 32'd1;
            if (if_id_flush) flush_cycles_d = flush_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule
